lab4_net_router_ctrl: RTL and testbench

- Control unit for the 3-port ring router. It sits directly beside the router datapath and consumes the datapath's input-queue status (inq_val, inq_dest0/1/2).
- It produces the crossbar selects (sel0/1/2) and the input-queue dequeue signals (inq_rdy).
- It computes a route per input, runs one round-robin arbiter per output port, and drives the output valid/ready handshake.
- Port map: 0 = west (from router id-1), 1 = terminal, 2 = east (to router id+1).

---
 rtl/lab4_net_router_ctrl.sv | 101 ++++++++++
 tb/tb_lab4_net_router_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/lab4_net_router_ctrl.sv
// Control unit for a 3-port ring router: per-input route computation, one round-robin
// arbiter per output, crossbar selects and input-queue dequeue strobes.
module lab4_net_router_ctrl #(
  parameter int p_router_id   = 0,
  parameter int p_num_routers = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] inq_val,
  input  logic [1:0] inq_dest0,
  input  logic [1:0] inq_dest1,
  input  logic [1:0] inq_dest2,
  output logic [2:0] inq_rdy,
  output logic [2:0] out_val,
  input  logic [2:0] out_rdy,
  output logic [1:0] sel0,
  output logic [1:0] sel1,
  output logic [1:0] sel2
);

  localparam logic [3:0] LP_N  = 4'(p_num_routers);
  localparam logic [3:0] LP_ID = 4'(p_router_id);

  // Hop distance eastward; two conditional subtractions cover the full dest/id range.
  function automatic logic [1:0] route_port(input logic [1:0] dest);
    logic [3:0] de;
    de = {2'b00, dest} + LP_N - LP_ID;
    if (de >= LP_N) de = de - LP_N;
    if (de >= LP_N) de = de - LP_N;
    if (de == 4'd0)
      return 2'd1;
    else if (de <= LP_N - de)
      return 2'd2;
    else
      return 2'd0;
  endfunction

  // Returns {hit, index}; the lowest offset from prio that requests wins.
  function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] prio);
    logic [2:0] res;
    int         t;
    res = 3'b000;
    for (int k = 2; k >= 0; k--) begin
      t = int'(prio) + k;
      if (t >= 3) t = t - 3;
      if (req[t]) res = {1'b1, 2'(t)};
    end
    return res;
  endfunction

  logic [2:0][1:0] r_prio;
  logic [2:0][1:0] w_dest;
  logic [2:0][1:0] w_route;
  logic [2:0][2:0] w_req;
  logic [2:0][1:0] w_sel;
  logic [2:0]      w_val;
  logic [2:0]      w_pick [3];

  assign w_dest[0] = inq_dest0;
  assign w_dest[1] = inq_dest1;
  assign w_dest[2] = inq_dest2;

  always_comb begin
    w_route = '0;
    w_req   = '0;
    w_val   = 3'b000;
    w_sel   = '0;
    inq_rdy = 3'b000;
    for (int p = 0; p < 3; p++) w_pick[p] = 3'b000;
    for (int i = 0; i < 3; i++) begin
      w_route[i] = route_port(w_dest[i]);
      // Masking by inq_val keeps an undriven dest field from reaching the outputs.
      for (int j = 0; j < 3; j++)
        w_req[j][i] = reset && inq_val[i] && (w_route[i] == 2'(j));
    end
    for (int j = 0; j < 3; j++) begin
      w_pick[j] = rr_pick(w_req[j], r_prio[j]);
      w_val[j]  = w_pick[j][2];
      w_sel[j]  = w_pick[j][2] ? w_pick[j][1:0] : 2'd0;
      if (w_val[j] && out_rdy[j]) inq_rdy[w_sel[j]] = 1'b1;
    end
  end

  assign out_val = w_val;
  assign sel0    = w_sel[0];
  assign sel1    = w_sel[1];
  assign sel2    = w_sel[2];

  // Priority advances past the grantee only on a completed transfer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_prio <= '0;
    end else begin
      for (int j = 0; j < 3; j++) begin
        if (w_val[j] && out_rdy[j])
          r_prio[j] <= (w_sel[j] == 2'd2) ? 2'd0 : w_sel[j] + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_lab4_net_router_ctrl.sv
// Bench for lab4_net_router_ctrl (id=1, 4 routers): directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a behavioural model.
module tb_lab4_net_router_ctrl;
  localparam int ID = 1;
  localparam int N  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] inq_val;
  logic [1:0] inq_dest0, inq_dest1, inq_dest2;
  logic [2:0] inq_rdy;
  logic [2:0] out_val;
  logic [2:0] out_rdy;
  logic [1:0] sel0, sel1, sel2;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;
  int m_prio[3];
  int m_next[3];

  lab4_net_router_ctrl #(.p_router_id(ID), .p_num_routers(N)) dut (
    .clk(clk), .reset(reset), .inq_val(inq_val),
    .inq_dest0(inq_dest0), .inq_dest1(inq_dest1), .inq_dest2(inq_dest2),
    .inq_rdy(inq_rdy), .out_val(out_val), .out_rdy(out_rdy),
    .sel0(sel0), .sel1(sel1), .sel2(sel2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Output port a message to dest takes from this router.
  function automatic int model_route(input int d);
    int de;
    de = ((d - ID) % N + N) % N;
    if (de == 0) return 1;
    if (de <= N - de) return 2;
    return 0;
  endfunction

  // Per-cycle model check at the falling edge; outputs are settled by then.
  always @(negedge clk) begin
    int dst[3];
    int ev, er;
    int es[3];
    dst[0] = int'(inq_dest0);
    dst[1] = int'(inq_dest1);
    dst[2] = int'(inq_dest2);
    ev = 0; er = 0;
    for (int j = 0; j < 3; j++) begin
      es[j] = 0;
      m_next[j] = m_prio[j];
      if (reset === 1'b1) begin
        for (int k = 0; k < 3; k++) begin
          int i;
          i = (m_prio[j] + k) % 3;
          if (inq_val[i] && model_route(dst[i]) == j && !ev[j]) begin
            ev[j] = 1'b1;
            es[j] = i;
          end
        end
        if (ev[j] && out_rdy[j]) begin
          er[es[j]] = 1'b1;
          m_next[j] = (es[j] + 1) % 3;
        end
      end else begin
        m_next[j] = 0;
      end
    end
    if (chk_en) begin
      chk("model out_val", int'(out_val), ev);
      chk("model inq_rdy", int'(inq_rdy), er);
      chk("model sel0", int'(sel0), es[0]);
      chk("model sel1", int'(sel1), es[1]);
      chk("model sel2", int'(sel2), es[2]);
    end
  end

  always @(posedge clk) begin
    for (int j = 0; j < 3; j++) m_prio[j] <= m_next[j];
  end

  // Apply inputs just after a rising edge, return just after the following falling edge.
  task automatic cyc(input logic rst, input logic [2:0] v, input logic [1:0] d0,
                     input logic [1:0] d1, input logic [1:0] d2, input logic [2:0] r);
    @(posedge clk);
    #1;
    reset = rst; inq_val = v; inq_dest0 = d0; inq_dest1 = d1; inq_dest2 = d2; out_rdy = r;
    @(negedge clk);
    #1;
  endtask

  initial begin
    int exp_sel[4];
    int exp_rdy[4];
    exp_sel = '{0, 1, 2, 0};
    exp_rdy = '{1, 2, 4, 1};
    for (int j = 0; j < 3; j++) begin m_prio[j] = 0; m_next[j] = 0; end
    reset = 1'b0; inq_val = 3'b000; inq_dest0 = 2'd0; inq_dest1 = 2'd0; inq_dest2 = 2'd0;
    out_rdy = 3'b000;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;

    cyc(1'b0, 3'b111, 2'd1, 2'd1, 2'd1, 3'b111);
    chk("reset out_val", int'(out_val), 0);
    chk("reset inq_rdy", int'(inq_rdy), 0);
    chk("reset sels", int'({sel0, sel1, sel2}), 0);

    cyc(1'b1, 3'b000, 2'd3, 2'd3, 2'd3, 3'b111);
    chk("idle out_val", int'(out_val), 0);

    cyc(1'b1, 3'b001, 2'd2, 2'd0, 2'd0, 3'b000);
    chk("route d2 out_val", int'(out_val), 3'b100);
    chk("route d2 sel2", int'(sel2), 0);
    cyc(1'b1, 3'b001, 2'd0, 2'd0, 2'd0, 3'b000);
    chk("route d0 out_val", int'(out_val), 3'b001);
    chk("route d0 sel0", int'(sel0), 0);
    cyc(1'b1, 3'b001, 2'd3, 2'd0, 2'd0, 3'b000);
    chk("route tie out_val", int'(out_val), 3'b100);
    chk("route tie inq_rdy", int'(inq_rdy), 0);

    for (int c = 0; c < 4; c++) begin
      cyc(1'b1, 3'b111, 2'd1, 2'd1, 2'd1, 3'b111);
      chk("rr sel1", int'(sel1), exp_sel[c]);
      chk("rr inq_rdy", int'(inq_rdy), exp_rdy[c]);
    end

    cyc(1'b1, 3'b010, 2'd0, 2'd1, 2'd0, 3'b010);
    chk("term out_val", int'(out_val), 3'b010);
    chk("term sel1", int'(sel1), 1);
    chk("term inq_rdy", int'(inq_rdy), 3'b010);

    cyc(1'b0, 3'b000, 2'd0, 2'd0, 2'd0, 3'b000);
    for (int c = 0; c < 3; c++) begin
      cyc(1'b1, 3'b111, 2'd1, 2'd1, 2'd1, 3'b101);
      chk("bp out_val", int'(out_val), 3'b010);
      chk("bp sel1", int'(sel1), 0);
      chk("bp inq_rdy", int'(inq_rdy), 0);
    end
    cyc(1'b1, 3'b111, 2'd1, 2'd1, 2'd1, 3'b010);
    chk("bp release inq_rdy", int'(inq_rdy), 3'b001);
    cyc(1'b1, 3'b111, 2'd1, 2'd1, 2'd1, 3'b010);
    chk("bp next sel1", int'(sel1), 1);

    cyc(1'b0, 3'b000, 2'd0, 2'd0, 2'd0, 3'b000);
    cyc(1'b1, 3'b111, 2'd1, 2'd1, 2'd1, 3'b010);
    chk("mid first inq_rdy", int'(inq_rdy), 3'b001);
    cyc(1'b0, 3'b111, 2'd1, 2'd1, 2'd1, 3'b010);
    chk("mid reset inq_rdy", int'(inq_rdy), 0);
    chk("mid reset out_val", int'(out_val), 0);
    cyc(1'b1, 3'b111, 2'd1, 2'd1, 2'd1, 3'b010);
    chk("mid after sel1", int'(sel1), 0);
    chk("mid after inq_rdy", int'(inq_rdy), 3'b001);

    for (int c = 0; c < 600; c++) begin
      cyc(($urandom_range(0, 24) != 0), 3'($urandom), 2'($urandom), 2'($urandom),
          2'($urandom), 3'($urandom));
    end

    @(posedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
